// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths and reset vector for the instruction-fetch stage.
// Every block that handles IF/ID payloads imports these.
package if_fetch_ctrl_pkg;

  localparam int FS_PC_W   = 32;
  localparam int FS_INST_W = 32;
  localparam int FS_DATA_W = FS_PC_W + FS_INST_W;

  localparam logic [FS_PC_W-1:0] FS_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, keeps at most one imem request in flight,
// buffers the returned instruction and hands {pc, inst} to the IF/ID register.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int              PC_W     = FS_PC_W,
  parameter int              INST_W   = FS_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = FS_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_W-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INST_W-1:0]      imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   fs_to_ds_reg_valid,
  output logic [PC_W+INST_W-1:0] fs_data,
  input  logic                   fs_ds_reg_allow_in
);

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLD    = 3'd3,
    S_DISCARD = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     buf_pc_q, buf_pc_d;
  logic [INST_W-1:0]   buf_inst_q, buf_inst_d;

  // State, PC and single-entry instruction buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RST;
      pc_q       <= RESET_PC;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

  // Next-state and output decode; outputs see only registered state and redirect_valid
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    buf_pc_d           = buf_pc_q;
    buf_inst_d         = buf_inst_q;
    imem_req_valid     = 1'b0;
    imem_req_addr      = pc_q;
    fs_to_ds_reg_valid = 1'b0;
    fs_data            = '0;

    case (state_q)
      S_RST: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        imem_req_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // Without a same-cycle response the stale one is still owed to us
          state_d = imem_resp_valid ? S_REQ : S_DISCARD;
        end else if (imem_resp_valid) begin
          buf_inst_d = imem_resp_data;
          buf_pc_d   = pc_q;
          state_d    = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_DISCARD: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        if (imem_resp_valid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DISCARD;
        end
      end

      S_HOLD: begin
        fs_to_ds_reg_valid = !redirect_valid;
        fs_data            = {buf_pc_q, buf_inst_q};
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (fs_ds_reg_allow_in) begin
          pc_d    = pc_q + PC_W'(4);
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end

      default: begin
        state_d = S_RST;
      end
    endcase
  end

endmodule
